fb_color_scan: RTL and testbench
================================

Name: fb_color_scan

Overview:
- Downstream consumer of the frame buffer's read port.
- On a start pulse, scans one full frame in raster order and drives the buffer's read address.
- Classifies each returned 12-bit RGB444 pixel against per-channel min/max thresholds.
- Accumulates match count and X/Y coordinate sums for centroid computation by a later stage.

Parameters:
- DATA_WIDTH, 12, pixel width; R=[11:8], G=[7:4], B=[3:0].
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- RD_LATENCY, 1, cycles from o_raddr to valid i_rdata (1..4).

Ports:
- i_clk  in  1  system clock; the frame buffer read clock is tied to this same clock.
- i_rst  in  1  reset: one clock; synchronous, active-high.
- i_start  in  1  single-cycle scan request; honoured only in IDLE.
- i_lo  in  12  per-channel lower thresholds, packed like a pixel.
- i_hi  in  12  per-channel upper thresholds, packed like a pixel.
- o_raddr  out  19  frame buffer read address.
- i_rdata  in  DATA_WIDTH  frame buffer read data.
- o_busy  out  1  high from start acceptance until o_done.
- o_done  out  1  one-cycle pulse; results valid from this cycle on.
- o_count  out  19  number of matching pixels.
- o_sumx  out  28  sum of x over matching pixels.
- o_sumy  out  28  sum of y over matching pixels.
- o_xmin, o_xmax  out  10  bounding box in x (see Optional Feature).
- o_ymin, o_ymax  out  9  bounding box in y (see Optional Feature).

Behaviour:
- Reset: state IDLE, o_raddr=0, o_busy=0, o_done=0, all result outputs 0, pipeline valids cleared.
- Reset during SCAN or DRAIN aborts the scan: no o_done, results return to 0.
- FSM IDLE->SCAN: on i_start in IDLE.
  - i_lo/i_hi are latched on this edge; changes during a scan have no effect.
  - o_busy rises; internal accumulators clear; x=y=0; o_raddr=0.
- SCAN: one address per cycle.
  - x increments and wraps at H_RES-1, then y increments.
  - o_raddr increments by 1, so o_raddr = y*H_RES+x; no multiplier.
  - After address N-1 (N=H_RES*V_RES) is issued, go to DRAIN.
- DRAIN: waits RD_LATENCY cycles for in-flight data, then goes to DONE.
- DONE: one cycle.
  - Accumulators copied to the output registers; o_done=1; o_busy falls on the same edge.
  - Then return to IDLE.
- Pipeline: a valid/x/y tag travels through a RD_LATENCY-deep shift register alongside each address. When the tag is valid, the pixel is checked.
- Match rule: pixel matches iff i_lo[c] <= pixel[c] <= i_hi[c] for all three channels (unsigned compare).
  - If lo>hi in any channel, nothing matches: count=0.
- Accumulate on match: count+=1, sumx+=x, sumy+=y.
  - Widths are sized so no overflow is possible at 640x480.
- Timing: o_raddr first equals 0 in cycle 0 after the start edge; o_done is high in cycle N+RD_LATENCY+1.
- i_start while not IDLE is ignored: no queuing.
- Outputs hold their values until the next DONE or reset.

Optional Feature:
- Macro: FB_COLOR_SCAN_BBOX_EN.
- Defined:
  - Track min/max x and y of matching pixels; published in DONE.
  - Min registers initialise to all-ones and max registers to 0 at scan start.
  - If count=0, all four bbox outputs report 0.
- Undefined: bbox ports remain and are tied to 0; no bbox logic is synthesised.

Decomposition:
- Package color_detect_pkg holds:
  - channel slice constants (R_MSB/LSB, G, B);
  - FSM state encoding (IDLE, SCAN, DRAIN, DONE);
  - default H_RES/V_RES;
  - result width constants (COUNT_W=19, SUM_W=28).
- Sub-module color_match: combinational compare of pixel against lo/hi, 1-bit output. Instantiated once.

Test Plan:
- 8x4 frame (H_RES=8, V_RES=4, RD_LATENCY=1), buffer all 0x000, thresholds lo=0x000/hi=0x000, start -> o_done in cycle 34; count=32, sumx=112, sumy=48; o_raddr sweeps 0..31 once.
- Same frame, only addr 13 (x=5, y=1) = 0xF00, lo=0xC00, hi=0xF33 -> count=1, sumx=5, sumy=1; with BBOX_EN, bbox=(5,5,1,1).
- RD_LATENCY=3, same stimulus -> o_done in cycle 36; results unchanged.
- lo=0x800, hi=0x7FF -> count=0, sums 0, bbox 0.
- i_start pulsed again mid-scan -> ignored; exactly one o_done.
- i_rst asserted at cycle 10 of a scan -> no o_done, outputs 0, state IDLE.
- After reset, a new start -> a correct full result.

Source files
------------

// File: rtl/color_detect_pkg.sv
// Shared constants, state encoding and channel helpers for the frame-buffer colour scanner.
package color_detect_pkg;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    localparam int COUNT_W = 19;
    localparam int SUM_W   = 28;
    localparam int ADDR_W  = 19;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Inclusive unsigned window test for one 4-bit channel.
    function automatic logic chan_in_range(input logic [3:0] v,
                                           input logic [3:0] lo,
                                           input logic [3:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/color_match.sv
// Combinational RGB444 window classifier: high when every channel lies within [lo, hi].
module color_match
    import color_detect_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic [DATA_WIDTH-1:0] pixel,
    input  logic [11:0]           lo,
    input  logic [11:0]           hi,
    output logic                  match
);

    // Per-channel window test; an inverted window (lo > hi) can never match.
    always_comb begin
        match = chan_in_range(pixel[R_MSB:R_LSB], lo[R_MSB:R_LSB], hi[R_MSB:R_LSB])
             && chan_in_range(pixel[G_MSB:G_LSB], lo[G_MSB:G_LSB], hi[G_MSB:G_LSB])
             && chan_in_range(pixel[B_MSB:B_LSB], lo[B_MSB:B_LSB], hi[B_MSB:B_LSB]);
    end

endmodule

// File: rtl/fb_color_scan.sv
// Raster-scans the frame buffer and accumulates colour-match count and centroid sums.
// Optional bounding-box tracking is enabled by defining FB_COLOR_SCAN_BBOX_EN.
module fb_color_scan
    import color_detect_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [11:0]           i_lo,
    input  logic [11:0]           i_hi,
    output logic [ADDR_W-1:0]     o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [COUNT_W-1:0]    o_count,
    output logic [SUM_W-1:0]      o_sumx,
    output logic [SUM_W-1:0]      o_sumy,
    output logic [X_W-1:0]        o_xmin,
    output logic [X_W-1:0]        o_xmax,
    output logic [Y_W-1:0]        o_ymin,
    output logic [Y_W-1:0]        o_ymax
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [X_W-1:0]    X_LAST     = X_W'(H_RES - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LATENCY - 1);

    scan_state_e         state_r;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [ADDR_W-1:0]   raddr_r;
    logic [11:0]         lo_r;
    logic [11:0]         hi_r;
    logic [2:0]          drain_cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [COUNT_W-1:0]  acc_cnt_r;
    logic [SUM_W-1:0]    acc_sx_r;
    logic [SUM_W-1:0]    acc_sy_r;
    logic [COUNT_W-1:0]  count_r;
    logic [SUM_W-1:0]    sumx_r;
    logic [SUM_W-1:0]    sumy_r;

    logic                pipe_vld_r [RD_LATENCY];
    logic [X_W-1:0]      pipe_x_r   [RD_LATENCY];
    logic [Y_W-1:0]      pipe_y_r   [RD_LATENCY];

    logic                match_s;
    logic                hit_s;
    logic                start_acc_s;
    logic [X_W-1:0]      tag_x_s;
    logic [Y_W-1:0]      tag_y_s;

    assign start_acc_s = (state_r == IDLE) && i_start;
    assign tag_x_s     = pipe_x_r[RD_LATENCY-1];
    assign tag_y_s     = pipe_y_r[RD_LATENCY-1];
    assign hit_s       = pipe_vld_r[RD_LATENCY-1] && match_s;

    color_match #(.DATA_WIDTH(DATA_WIDTH)) u_match (
        .pixel (i_rdata),
        .lo    (lo_r),
        .hi    (hi_r),
        .match (match_s)
    );

    // Coordinate tag pipeline aligned with the buffer read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_r[i] <= 1'b0;
                pipe_x_r[i]   <= '0;
                pipe_y_r[i]   <= '0;
            end
        end else begin
            pipe_vld_r[0] <= (state_r == SCAN);
            pipe_x_r[0]   <= x_r;
            pipe_y_r[0]   <= y_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_x_r[i]   <= pipe_x_r[i-1];
                pipe_y_r[i]   <= pipe_y_r[i-1];
            end
        end
    end

    // Scan control FSM with address generation and result publication.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            x_r         <= '0;
            y_r         <= '0;
            raddr_r     <= '0;
            lo_r        <= '0;
            hi_r        <= '0;
            drain_cnt_r <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            count_r     <= '0;
            sumx_r      <= '0;
            sumy_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        state_r <= SCAN;
                        busy_r  <= 1'b1;
                        lo_r    <= i_lo;
                        hi_r    <= i_hi;
                        raddr_r <= '0;
                        x_r     <= '0;
                        y_r     <= '0;
                    end
                end
                SCAN: begin
                    if (raddr_r == LAST_ADDR) begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= 3'd0;
                    end else begin
                        raddr_r <= raddr_r + 19'd1;
                        if (x_r == X_LAST) begin
                            x_r <= '0;
                            y_r <= y_r + 9'd1;
                        end else begin
                            x_r <= x_r + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 3'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    count_r <= acc_cnt_r;
                    sumx_r  <= acc_sx_r;
                    sumy_r  <= acc_sy_r;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Match count and coordinate sum accumulators.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc_s) begin
            acc_cnt_r <= '0;
            acc_sx_r  <= '0;
            acc_sy_r  <= '0;
        end else if (hit_s) begin
            acc_cnt_r <= acc_cnt_r + COUNT_W'(1);
            acc_sx_r  <= acc_sx_r + SUM_W'(tag_x_s);
            acc_sy_r  <= acc_sy_r + SUM_W'(tag_y_s);
        end
    end

`ifdef FB_COLOR_SCAN_BBOX_EN
    logic [X_W-1:0] acc_xmin_r, acc_xmax_r, xmin_r, xmax_r;
    logic [Y_W-1:0] acc_ymin_r, acc_ymax_r, ymin_r, ymax_r;

    // Bounding-box trackers: mins start at all-ones, maxes at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc_s) begin
            acc_xmin_r <= '1;
            acc_xmax_r <= '0;
            acc_ymin_r <= '1;
            acc_ymax_r <= '0;
        end else if (hit_s) begin
            if (tag_x_s < acc_xmin_r) acc_xmin_r <= tag_x_s;
            if (tag_x_s > acc_xmax_r) acc_xmax_r <= tag_x_s;
            if (tag_y_s < acc_ymin_r) acc_ymin_r <= tag_y_s;
            if (tag_y_s > acc_ymax_r) acc_ymax_r <= tag_y_s;
        end
    end

    // Publish the box; an empty match set reports an all-zero box.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_r == DONE && acc_cnt_r == '0)) begin
            xmin_r <= '0;
            xmax_r <= '0;
            ymin_r <= '0;
            ymax_r <= '0;
        end else if (state_r == DONE) begin
            xmin_r <= acc_xmin_r;
            xmax_r <= acc_xmax_r;
            ymin_r <= acc_ymin_r;
            ymax_r <= acc_ymax_r;
        end
    end

    assign o_xmin = xmin_r;
    assign o_xmax = xmax_r;
    assign o_ymin = ymin_r;
    assign o_ymax = ymax_r;
`else
    assign o_xmin = '0;
    assign o_xmax = '0;
    assign o_ymin = '0;
    assign o_ymax = '0;
`endif

    assign o_raddr = raddr_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;
    assign o_count = count_r;
    assign o_sumx  = sumx_r;
    assign o_sumy  = sumy_r;

endmodule

// File: tb/tb_fb_color_scan.sv
// Self-checking bench: 8x4 frame scanned by two instances (read latency 1 and 3) against a frame-level model.
module tb_fb_color_scan;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] lo, hi;

    logic [18:0] raddr1, raddr3;
    logic [11:0] rdata1, rdata3;
    logic        busy1, busy3, done1, done3;
    logic [18:0] count1, count3;
    logic [27:0] sumx1, sumx3, sumy1, sumy3;
    logic [9:0]  xmin1, xmax1, xmin3, xmax3;
    logic [8:0]  ymin1, ymax1, ymin3, ymax3;

    logic [11:0] mem [N];
    logic [11:0] p3  [3];

    int total  = 0;
    int passed = 0;
    int e_cnt, e_sx, e_sy, e_xmin, e_xmax, e_ymin, e_ymax;

    always #5 clk = ~clk;

    // Frame buffer read ports: one-cycle and three-cycle synchronous reads.
    always @(posedge clk) begin
        rdata1 <= mem[raddr1[4:0]];
        p3[0]  <= mem[raddr3[4:0]];
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign rdata3 = p3[2];

    fb_color_scan #(.DATA_WIDTH(12), .H_RES(H), .V_RES(V), .RD_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_lo(lo), .i_hi(hi),
        .o_raddr(raddr1), .i_rdata(rdata1), .o_busy(busy1), .o_done(done1),
        .o_count(count1), .o_sumx(sumx1), .o_sumy(sumy1),
        .o_xmin(xmin1), .o_xmax(xmax1), .o_ymin(ymin1), .o_ymax(ymax1)
    );

    fb_color_scan #(.DATA_WIDTH(12), .H_RES(H), .V_RES(V), .RD_LATENCY(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_lo(lo), .i_hi(hi),
        .o_raddr(raddr3), .i_rdata(rdata3), .o_busy(busy3), .o_done(done3),
        .o_count(count3), .o_sumx(sumx3), .o_sumy(sumy3),
        .o_xmin(xmin3), .o_xmax(xmax3), .o_ymin(ymin3), .o_ymax(ymax3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Frame-level reference: walk every pixel and apply the inclusive window rule.
    task automatic model();
        int mx0, mx1, my0, my1;
        e_cnt = 0; e_sx = 0; e_sy = 0;
        mx0 = H; mx1 = -1; my0 = V; my1 = -1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                int pix, ok;
                pix = int'(mem[y*H + x]);
                ok  = 1;
                for (int c = 0; c < 3; c++) begin
                    int pv, lv, hv;
                    pv = (pix >> (4*c)) & 15;
                    lv = (int'(lo) >> (4*c)) & 15;
                    hv = (int'(hi) >> (4*c)) & 15;
                    if (pv < lv || pv > hv) ok = 0;
                end
                if (ok == 1) begin
                    e_cnt++; e_sx += x; e_sy += y;
                    if (x < mx0) mx0 = x;
                    if (x > mx1) mx1 = x;
                    if (y < my0) my0 = y;
                    if (y > my1) my1 = y;
                end
            end
        end
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
`ifdef FB_COLOR_SCAN_BBOX_EN
        if (e_cnt > 0) begin
            e_xmin = mx0; e_xmax = mx1; e_ymin = my0; e_ymax = my1;
        end
`endif
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) mem[i] = 12'h000;
            else           mem[i] = 12'($urandom_range(0, 4095));
        end
    endtask

    // One scan on both instances; optional mid-scan restart and mid-scan reset.
    task automatic run_scan(input string name, input int restart_at, input int rst_at);
        int d1, d3, n1, n3;
        bit sw1, sw3;
        model();
        d1 = -1; d3 = -1; n1 = 0; n3 = 0; sw1 = 1'b1; sw3 = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy1_c0"}, 32'(busy1), 32'd1);
        check({name, ".busy3_c0"}, 32'(busy3), 32'd1);
        for (int c = 0; c < 80; c++) begin
            if (c < N && rst_at < 0) begin
                if (raddr1 !== 19'(c)) sw1 = 1'b0;
                if (raddr3 !== 19'(c)) sw3 = 1'b0;
            end
            if (done1 === 1'b1) begin n1++; if (d1 < 0) d1 = c; end
            if (done3 === 1'b1) begin n3++; if (d3 < 0) d3 = c; end
            start = (c == restart_at);
            rst   = (c == rst_at);
            if (c == restart_at) begin
                lo = ~lo;
                hi = ~hi;
            end
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at < 0) begin
            check({name, ".done_cyc1"}, 32'(d1), 32'(N + 2));
            check({name, ".done_cyc3"}, 32'(d3), 32'(N + 4));
            check({name, ".done_n1"}, 32'(n1), 32'd1);
            check({name, ".done_n3"}, 32'(n3), 32'd1);
            check({name, ".sweep1"}, 32'(sw1), 32'd1);
            check({name, ".sweep3"}, 32'(sw3), 32'd1);
            check({name, ".count1"}, 32'(count1), 32'(e_cnt));
            check({name, ".count3"}, 32'(count3), 32'(e_cnt));
            check({name, ".sumx1"}, 32'(sumx1), 32'(e_sx));
            check({name, ".sumx3"}, 32'(sumx3), 32'(e_sx));
            check({name, ".sumy1"}, 32'(sumy1), 32'(e_sy));
            check({name, ".sumy3"}, 32'(sumy3), 32'(e_sy));
            check({name, ".bbox1"}, {8'(xmin1), 8'(xmax1), 8'(ymin1), 8'(ymax1)},
                  {8'(e_xmin), 8'(e_xmax), 8'(e_ymin), 8'(e_ymax)});
            check({name, ".bbox3"}, {8'(xmin3), 8'(xmax3), 8'(ymin3), 8'(ymax3)},
                  {8'(e_xmin), 8'(e_xmax), 8'(e_ymin), 8'(e_ymax)});
        end else begin
            check({name, ".no_done1"}, 32'(n1), 32'd0);
            check({name, ".no_done3"}, 32'(n3), 32'd0);
            check({name, ".zero1"}, 32'(count1) | 32'(sumx1) | 32'(sumy1) | 32'(raddr1), 32'd0);
            check({name, ".zero3"}, 32'(count3) | 32'(sumx3) | 32'(sumy3) | 32'(raddr3), 32'd0);
        end
        check({name, ".busy1_end"}, 32'(busy1), 32'd0);
        check({name, ".busy3_end"}, 32'(busy3), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; lo = 12'h000; hi = 12'h000;
        fill(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.raddr", 32'(raddr1) | 32'(raddr3), 32'd0);
        check("rst.busy", {31'd0, busy1 | busy3}, 32'd0);
        check("rst.done", {31'd0, done1 | done3}, 32'd0);
        check("rst.count", 32'(count1) | 32'(count3), 32'd0);
        check("rst.sums", 32'(sumx1) | 32'(sumy1) | 32'(sumx3) | 32'(sumy3), 32'd0);

        // Uniform black frame, window exactly black: every pixel matches.
        fill(0); lo = 12'h000; hi = 12'h000;
        run_scan("all_zero", -1, -1);

        // Single red pixel at (5,1).
        fill(0); mem[13] = 12'hF00; lo = 12'hC00; hi = 12'hF33;
        run_scan("single", -1, -1);

        // Inverted red window on a random frame: nothing may match.
        fill(1); lo = 12'h800; hi = 12'h7FF;
        run_scan("inverted", -1, -1);

        // Restart pulse mid-scan plus threshold changes: ignored.
        fill(0); mem[13] = 12'hF00; mem[30] = 12'hE21; lo = 12'hC00; hi = 12'hF33;
        run_scan("restart", 5, -1);

        // Reset at cycle 10 aborts a scan that would have matched everything.
        fill(0); lo = 12'h000; hi = 12'hFFF;
        run_scan("abort", -1, 10);

        // Fresh start after the abort.
        fill(1); lo = 12'h000; hi = 12'hFFF;
        run_scan("after_rst", -1, -1);

        // Random frames with random, non-inverted windows.
        for (int k = 0; k < 3; k++) begin
            int l0, l1, l2;
            fill(1);
            l0 = $urandom_range(0, 7); l1 = $urandom_range(0, 7); l2 = $urandom_range(0, 7);
            lo = {4'(l2), 4'(l1), 4'(l0)};
            hi = {4'($urandom_range(l2, 15)), 4'($urandom_range(l1, 15)), 4'($urandom_range(l0, 15))};
            run_scan("random", -1, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
